// File: rtl/im_loader_pkg.sv
// Shared types and sizing for the instruction-memory loader.
package im_loader_pkg;
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam int WORD_BYTES   = 4;
  localparam int IM_ADDR_W    = 8;
  localparam int IM_MAX_WORDS = 64;
endpackage

// File: rtl/im_loader_if.sv
// Host byte stream plus instruction-RAM write port of the loader.
interface im_loader_if
  import im_loader_pkg::*;
#(
  parameter int ADDR_W = IM_ADDR_W
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;

  modport master (output in_valid, in_data, input in_ready, we, waddr, wdata);
  modport slave  (input in_valid, in_data, output in_ready, we, waddr, wdata);
endinterface

// File: rtl/im_word_assembler.sv
// Packs accepted bytes big-endian into a 32-bit word; word_ready flags the 4th byte.
module im_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic        word_ready,
  output logic [31:0] word
);
  logic [31:0] shift;
  logic [1:0]  cnt;

  // word is the value the shift register takes if byte_in is accepted now
  assign word       = {shift[23:0], byte_in};
  assign word_ready = accept && (cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shift <= '0;
      cnt   <= '0;
    end else if (accept) begin
      shift <= word;
      cnt   <= cnt + 2'd1;
    end
  end
endmodule

// File: rtl/im_loader.sv
// Loads a counted byte stream into instruction RAM, holding the CPU in reset meanwhile.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int ADDR_W    = IM_ADDR_W,
  parameter int MAX_WORDS = IM_MAX_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  len,
  input  logic        abort,
  im_loader_if.slave  bus,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam logic [6:0]        MAX_LEN   = 7'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(WORD_BYTES);

  state_t            state;
  logic [6:0]        len_q;
  logic [6:0]        word_cnt;
  logic [ADDR_W-1:0] addr;
  logic              accept;
  logic              clear;
  logic              word_ready;
  logic [31:0]       word;

  // Abort wins over a byte offered in the same cycle
  assign accept = (state == RECV) && bus.in_valid && !abort;
  assign clear  = ((state == IDLE) && start) ||
                  (((state == RECV) || (state == WRITE)) && abort);

  im_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .accept     (accept),
    .byte_in    (bus.in_data),
    .word_ready (word_ready),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      len_q        <= '0;
      word_cnt     <= '0;
      addr         <= '0;
      bus.in_ready <= 1'b0;
      bus.we       <= 1'b0;
      bus.waddr    <= '0;
      bus.wdata    <= '0;
      cpu_hold     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      bus.we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len == 7'd0) begin
              state    <= DONE;
              cpu_hold <= 1'b1;
              err      <= 1'b0;
            end else if (len > MAX_LEN) begin
              err  <= 1'b1;
              done <= 1'b0;
            end else begin
              state        <= RECV;
              len_q        <= len;
              word_cnt     <= '0;
              addr         <= '0;
              bus.waddr    <= '0;
              done         <= 1'b0;
              err          <= 1'b0;
              bus.in_ready <= 1'b1;
              cpu_hold     <= 1'b1;
              busy         <= 1'b1;
            end
          end
        end
        RECV: begin
          if (abort) begin
            state        <= IDLE;
            err          <= 1'b1;
            bus.in_ready <= 1'b0;
            cpu_hold     <= 1'b0;
            busy         <= 1'b0;
          end else if (word_ready) begin
            state        <= WRITE;
            bus.in_ready <= 1'b0;
            bus.we       <= 1'b1;
            bus.wdata    <= word;
            bus.waddr    <= addr;
          end
        end
        WRITE: begin
          if (abort) begin
            state    <= IDLE;
            err      <= 1'b1;
            cpu_hold <= 1'b0;
            busy     <= 1'b0;
          end else begin
            addr     <= addr + ADDR_STEP;
            word_cnt <= word_cnt + 7'd1;
            if ((word_cnt + 7'd1) == len_q) begin
              state <= DONE;
              busy  <= 1'b0;
            end else begin
              state        <= RECV;
              bus.in_ready <= 1'b1;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          done     <= 1'b1;
          cpu_hold <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_im_loader.sv
// Randomized bench for im_loader: cycle-accurate transaction model plus literal RAM checks.
module tb_im_loader;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] len = '0;
  logic       abort = 1'b0;
  logic       cpu_hold, busy, done, err;

  im_loader_if #(.ADDR_W(8)) bus ();

  im_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .abort    (abort),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // RAM image and write log captured from the write port
  logic [31:0] ram [64];
  int          wcount = 0;
  logic [7:0]  last_waddr = '0;

  // Behavioural model: words scheduled from accepted bytes, outputs predicted per cycle
  int          cyc = 0;
  int          m_wr_cyc = -1;
  int          m_done_cyc = -1;
  int          m_left = 0;
  int          m_nbytes = 0;
  bit          m_loading = 0;
  bit          m_done = 0;
  bit          m_err = 0;
  logic [7:0]  m_addr = '0, m_waddr = '0, m_pend_addr = '0;
  logic [31:0] m_acc = '0, m_wdata = '0, m_pend_data = '0;

  always @(negedge clk) begin : model
    bit exp_we;
    bit exp_rdy;
    cyc++;
    exp_we  = (cyc == m_wr_cyc);
    exp_rdy = m_loading && !exp_we;
    if (exp_we) begin
      m_waddr = m_pend_addr;
      m_wdata = m_pend_data;
    end
    chk("we",       32'(bus.we),       32'(exp_we));
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    chk("cpu_hold", 32'(cpu_hold),     32'(m_loading || (cyc == m_done_cyc)));
    chk("busy",     32'(busy),         32'(m_loading));
    chk("done",     32'(done),         32'(m_done));
    chk("err",      32'(err),          32'(m_err));
    chk("waddr",    32'(bus.waddr),    32'(m_waddr));
    chk("wdata",    bus.wdata,         m_wdata);

    if (bus.we === 1'b1) begin
      ram[bus.waddr[7:2]] = bus.wdata;
      last_waddr = bus.waddr;
      wcount++;
    end

    if (rst) begin
      m_loading = 0; m_done = 0; m_err = 0;
      m_wr_cyc = -1; m_done_cyc = -1;
      m_waddr = '0; m_wdata = '0; m_nbytes = 0; m_acc = '0;
    end else if (m_loading && abort) begin
      m_loading = 0; m_err = 1; m_wr_cyc = -1;
    end else if (m_loading) begin
      if (exp_we) begin
        m_addr = m_addr + 8'd4;
        m_left--;
        if (m_left == 0) begin
          m_loading  = 0;
          m_done_cyc = cyc + 1;
        end
      end else if (bus.in_valid) begin
        m_acc = {m_acc[23:0], bus.in_data};
        m_nbytes++;
        if (m_nbytes == 4) begin
          m_nbytes    = 0;
          m_pend_addr = m_addr;
          m_pend_data = m_acc;
          m_wr_cyc    = cyc + 1;
        end
      end
    end else if (cyc == m_done_cyc) begin
      m_done = 1;
    end else if (start) begin
      if (len == 7'd0) begin
        m_done_cyc = cyc + 1;
        m_err      = 0;
      end else if (len > 7'd64) begin
        m_err  = 1;
        m_done = 0;
      end else begin
        m_loading = 1; m_left = int'(len); m_addr = '0; m_nbytes = 0;
        m_done = 0; m_err = 0; m_waddr = '0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    len   = 7'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    got = 0;
    n   = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      got = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("accept", 32'(got), 32'd1);
    if (gap > 0) begin
      bus.in_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  logic [7:0] bytes_q [$];

  // Sends bytes_q as an n-word load and returns in IDLE right after the DONE cycle
  task automatic run_load(input int n, input int gap, input int max_rnd_gap);
    do_start(n);
    for (int i = 0; i < bytes_q.size(); i++) begin
      int g;
      g = (max_rnd_gap > 0) ? int'($urandom_range(0, max_rnd_gap)) : gap;
      send_byte(bytes_q[i], (i == bytes_q.size() - 1) ? 0 : g);
    end
    bus.in_valid = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("rst_waddr",    32'(bus.waddr), 32'd0);
    tick();

    // Nominal two-word load
    bytes_q = '{8'h20, 8'h10, 8'h00, 8'h00, 8'h20, 8'h11, 8'h00, 8'h00};
    w0 = wcount;
    run_load(2, 0, 0);
    chk("nom_ram0",  ram[0], 32'h2010_0000);
    chk("nom_ram1",  ram[1], 32'h2011_0000);
    chk("nom_count", 32'(wcount - w0), 32'd2);
    chk("nom_done",  32'(done), 32'd1);
    chk("nom_hold",  32'(cpu_hold), 32'd0);

    // Host valid toggled every other cycle
    bytes_q = '{8'h00, 8'h00, 8'h90, 8'h24};
    w0 = wcount;
    run_load(1, 1, 0);
    chk("gap_ram0",  ram[0], 32'h0000_9024);
    chk("gap_count", 32'(wcount - w0), 32'd1);

    // Zero-length load
    w0 = wcount;
    do_start(0);
    chk("len0_hold", 32'(cpu_hold), 32'd1);
    tick();
    chk("len0_done",  32'(done), 32'd1);
    chk("len0_count", 32'(wcount - w0), 32'd0);

    // Oversized load is rejected
    do_start(65);
    chk("len65_err",   32'(err), 32'd1);
    chk("len65_done",  32'(done), 32'd0);
    chk("len65_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("len65_idle", 32'(cpu_hold), 32'd0);

    // Full-capacity load, incrementing bytes, random host gaps
    bytes_q = {};
    for (int i = 0; i < 256; i++) bytes_q.push_back(8'(i));
    w0 = wcount;
    run_load(64, 0, 1);
    chk("full_count", 32'(wcount - w0), 32'd64);
    chk("full_last",  32'(last_waddr), 32'h0000_00FC);
    chk("full_ram0",  ram[0],  32'h0001_0203);
    chk("full_ram63", ram[63], 32'hFCFD_FEFF);
    chk("full_done",  32'(done), 32'd1);

    // Abort after six bytes of a three-word load
    w0 = wcount;
    do_start(3);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(0, 255)), 0);
    bus.in_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_err",   32'(err), 32'd1);
    chk("abort_done",  32'(done), 32'd0);
    chk("abort_hold",  32'(cpu_hold), 32'd0);
    chk("abort_we",    32'(bus.we), 32'd0);
    chk("abort_count", 32'(wcount - w0), 32'd1);
    tick();

    // Reset with two bytes held, then a clean one-word load
    do_start(1);
    send_byte(8'h5A, 0);
    send_byte(8'hA5, 0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    chk("mid_rst_hold",  32'(cpu_hold), 32'd0);
    chk("mid_rst_wdata", bus.wdata, 32'd0);
    tick();
    bytes_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load(1, 0, 0);
    chk("post_rst_ram0",  ram[0], 32'hAABB_CCDD);
    chk("post_rst_waddr", 32'(last_waddr), 32'd0);

    // Random short loads
    for (int k = 0; k < 6; k++) begin
      int n;
      n = int'($urandom_range(1, 6));
      bytes_q = {};
      for (int i = 0; i < 4 * n; i++) bytes_q.push_back(8'($urandom_range(0, 255)));
      run_load(n, 0, 2);
      repeat (int'($urandom_range(0, 2))) tick();
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/im_loader.md
# im_loader

Byte-stream instruction-memory writer for the single-cycle core. It accepts a word count and a stream of bytes from a host link, and packs each 4 bytes big-endian (first byte = bits 31:24) into a 32-bit instruction. It writes each instruction into the writable instruction RAM at consecutive word-aligned byte addresses starting at 0x00, the same 8-bit byte addressing the fetch side uses. It holds the CPU in reset while loading.

## Interface
- `ADDR_W`, 8: byte-address width of the instruction memory.
- `MAX_WORDS`, 64: capacity in words (2^ADDR_W / 4).
- `clk`  in  1  — single clock; all state changes on rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `start`  in  1  — begin a load; sampled only in IDLE.
- `len`  in  7  — number of words to load, sampled with `start`; valid range 0..MAX_WORDS.
- `abort`  in  1  — cancel the load in progress.
- `in_valid`  in  1  — host byte valid.
- `in_data`  in  8  — host byte.
- `in_ready`  out  1  — loader can accept a byte.
- `we`  out  1  — instruction RAM write enable, one-cycle pulse.
- `waddr`  out  ADDR_W  — byte address of the write, always a multiple of 4.
- `wdata`  out  32  — assembled instruction.
- `cpu_hold`  out  1  — holds the CPU/PC in reset while high.
- `busy`  out  1  — high in RECV and WRITE.
- `done`  out  1  — sticky; last load completed.
- `err`  out  1  — sticky; last load was rejected or aborted.

## Operation
- States: IDLE, RECV, WRITE, DONE.
- **IDLE**
  - `start` with 1 ≤ `len` ≤ MAX_WORDS: latch `len`, clear word counter, byte counter, `waddr`, `done` and `err`; go to RECV.
  - `start` with `len`=0: go to DONE, writing nothing.
  - `start` with `len` > MAX_WORDS: set `err`, clear `done`, stay in IDLE.
- **RECV**
  - `in_ready`=1.
  - Each cycle with `in_valid`&&`in_ready`: `shift = {shift[23:0], in_data}` and increment the byte counter.
  - On acceptance of the 4th byte: go to WRITE.
- **WRITE**
  - `in_ready`=0, `we`=1, `wdata`=shift, `waddr`=current address.
  - Next cycle: address += 4, word counter += 1, byte counter cleared.
  - If the word counter now equals `len`, go to DONE; otherwise go to RECV.
- **DONE**: one cycle; set `done`, then go to IDLE.
- **cpu_hold**: high in RECV, WRITE and DONE; low in IDLE.
- **abort**
  - Takes effect in RECV or WRITE and has priority over all other events.
  - Next state is IDLE with `err` set.
  - The partial word is discarded and there is no `we` that cycle.
  - Words already written stay in RAM.
  - `abort` in IDLE or DONE is ignored.
- **Address**: the last write is at `(len-1)*4`, at most 0xFC. The address never wraps.
- **Reset values**
  - State = IDLE.
  - `in_ready`, `we`, `cpu_hold`, `busy`, `done` and `err` = 0.
  - `waddr`, `wdata` and the internal counters = 0.

## Timing
- `start` is accepted at edge N. RECV begins at N+1, and `in_ready` is high from N+1.
- Byte acceptance takes one cycle per byte when `in_valid` is held high.
- After the 4th byte is accepted at edge M, `we` is high in cycle M+1.
- At most one word per 5 cycles. A full 64-word load with a gapless host takes 320 cycles plus 1 DONE cycle.
- `done` rises at the edge leaving DONE. `cpu_hold` falls at that same edge.
- `in_valid` low stalls RECV indefinitely. There is no timeout.
- `wdata`/`waddr` are registered and hold their value after `we` drops.
- `rst` mid-load returns everything to reset values at the next edge.

## Structure
- `im_loader_pkg` holds:
  - the state enum (IDLE/RECV/WRITE/DONE);
  - `WORD_BYTES`=4;
  - `IM_ADDR_W`=8;
  - `IM_MAX_WORDS`=64.
- `im_word_assembler` is the one natural sub-module. It contains the 32-bit shift register and the 2-bit byte counter, with `word_ready` output on the 4th byte.
- The FSM, address counter and word counter live in `im_loader`.

## Test plan
- **Nominal load**: `len`=2, bytes 20 10 00 00 20 11 00 00.
  - Expect `we` pulses with (0x00, 0x20100000) then (0x04, 0x20110000).
  - Then `done`=1, `cpu_hold`=0.
- **Back-pressure gaps**: `len`=1, `in_valid` toggled every other cycle, bytes 00 00 90 24.
  - Expect a single write (0x00, 0x00009024).
  - `we` occurs exactly one cycle after the 4th accepted byte.
- **Boundaries**
  - `len`=64 with an incrementing pattern: last write at `waddr`=0xFC, exactly 64 `we` pulses.
  - `len`=0: `done` is set, no `we`.
  - `len`=65: `err` is set, state stays IDLE.
- **Abort**: `len`=3, abort after 6 bytes.
  - Expect exactly one write (word 0).
  - Expect no `we` for the partial word, `err`=1, `done`=0, `cpu_hold`=0 the next cycle.
- **Reset mid-load**: `rst` during RECV with 2 bytes held.
  - All outputs return to 0.
  - A following `len`=1 load writes the correct word at 0x00 with no stale bytes.
